// File: rtl/pw_phase_shift_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pw_phase_shift_ctrl_if
// Brief   : Register-block / MMCM phase-shift signal bundle for the sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface pw_phase_shift_ctrl_if #(
  parameter int pSTEP_WIDTH  = 16,
  parameter int pPHASE_WIDTH = 11
);
  logic                    I_start;
  logic [pSTEP_WIDTH-1:0]  I_steps;
  logic                    I_abort;
  logic                    I_phase_clear;
  logic                    I_locked;
  logic                    I_psdone;
  logic                    O_psen;
  logic                    O_psincdec;
  logic                    O_busy;
  logic                    O_done;
  logic                    O_aborted;
  logic                    O_timeout;
  logic [pSTEP_WIDTH-1:0]  O_remaining;
  logic [pPHASE_WIDTH-1:0] O_phase;

  modport master (
    output I_start, I_steps, I_abort, I_phase_clear, I_locked, I_psdone,
    input  O_psen, O_psincdec, O_busy, O_done, O_aborted, O_timeout,
           O_remaining, O_phase
  );

  modport slave (
    input  I_start, I_steps, I_abort, I_phase_clear, I_locked, I_psdone,
    output O_psen, O_psincdec, O_busy, O_done, O_aborted, O_timeout,
           O_remaining, O_phase
  );
endinterface
`default_nettype wire

// File: rtl/pw_phase_shift_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : pw_phase_shift_ctrl
// Brief   : MMCM dynamic phase-shift sequencer with phase tracking and timeout.
// Revision: 1.0 - initial release
// ============================================================================
module pw_phase_shift_ctrl #(
  parameter int pSTEP_WIDTH   = 16,
  parameter int pPHASE_PERIOD = 1120,
  parameter int pPHASE_WIDTH  = 11,
  parameter int pTIMEOUT      = 1023
) (
  input wire logic             cwusb_clk,
  input wire logic             reset_n,
  pw_phase_shift_ctrl_if.slave bus
);

  localparam int c_TIMER_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT + 1) : 1;
  localparam logic [c_TIMER_W-1:0]    c_TIMEOUT   = c_TIMER_W'(pTIMEOUT);
  localparam logic [pPHASE_WIDTH-1:0] c_PHASE_MAX = pPHASE_WIDTH'(pPHASE_PERIOD - 1);
  localparam logic [pSTEP_WIDTH-1:0]  c_STEP_ONE  = pSTEP_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                  r_state;
  logic [c_TIMER_W-1:0]    r_timer;
  logic                    r_abort_pend;
  logic                    r_psen;
  logic                    r_psincdec;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_aborted;
  logic                    r_timeout;
  logic [pSTEP_WIDTH-1:0]  r_remaining;
  logic [pPHASE_WIDTH-1:0] r_phase;

  logic [pSTEP_WIDTH-1:0]  w_step_mag;
  logic [pSTEP_WIDTH-1:0]  w_rem_next;
  logic [pPHASE_WIDTH-1:0] w_phase_next;
  logic                    w_abort;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1) unsigned.
  assign w_step_mag = bus.I_steps[pSTEP_WIDTH-1] ? (~bus.I_steps + c_STEP_ONE) : bus.I_steps;
  assign w_rem_next = r_remaining - c_STEP_ONE;
  assign w_abort    = r_abort_pend | bus.I_abort;

  always_comb begin
    w_phase_next = r_phase;
    if (r_psincdec) begin
      w_phase_next = (r_phase == c_PHASE_MAX) ? '0 : r_phase + 1'b1;
    end else begin
      w_phase_next = (r_phase == '0) ? c_PHASE_MAX : r_phase - 1'b1;
    end
  end

  always_ff @(posedge cwusb_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_abort_pend <= 1'b0;
      r_psen       <= 1'b0;
      r_psincdec   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_timeout    <= 1'b0;
      r_remaining  <= '0;
      r_phase      <= '0;
    end else begin
      r_psen <= 1'b0;
      r_done <= 1'b0;
      if (r_busy && bus.I_abort) begin
        r_abort_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.I_phase_clear) begin
            r_phase <= '0;
          end
          if (bus.I_start) begin
            r_timeout    <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            if (bus.I_steps == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_psincdec  <= ~bus.I_steps[pSTEP_WIDTH-1];
              r_remaining <= w_step_mag;
              r_busy      <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_abort) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
            r_state   <= S_DONE;
          end else if (bus.I_locked) begin
            r_psen  <= 1'b1;
            r_timer <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A psdone arriving on the timeout cycle still counts as a completed step.
          if (bus.I_psdone) begin
            r_phase     <= w_phase_next;
            r_remaining <= w_rem_next;
            if ((w_rem_next == '0) || w_abort) begin
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_aborted <= (w_rem_next != '0);
              r_state   <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
            end
          end else if (r_timer == c_TIMEOUT) begin
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_ERR;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DONE: begin
          r_abort_pend <= 1'b0;
          r_state      <= S_IDLE;
        end
        S_ERR: begin
          r_abort_pend <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.O_psen      = r_psen;
  assign bus.O_psincdec  = r_psincdec;
  assign bus.O_busy      = r_busy;
  assign bus.O_done      = r_done;
  assign bus.O_aborted   = r_aborted;
  assign bus.O_timeout   = r_timeout;
  assign bus.O_remaining = r_remaining;
  assign bus.O_phase     = r_phase;

endmodule
`default_nettype wire

// File: doc/pw_phase_shift_ctrl.md
Name: pw_phase_shift_ctrl

Overview:
Sequencer for the trigger-clock MMCM dynamic phase-shift port (psen/psincdec/psdone). It takes a signed step request from the register block and issues one psen pulse per step, waiting for psdone between pulses. It tracks the absolute trigger-clock phase modulo one period and flags a hung shift.
It runs in the USB register clock domain, which is also the MMCM psclk, and replaces the direct register-driven psen/psincdec.

Parameters:
pSTEP_WIDTH, 16, width of the signed step request (two's complement).
pPHASE_PERIOD, 1120, number of fine steps in one full trigger-clock period; tracked phase wraps modulo this value.
pPHASE_WIDTH, 11, width of the tracked-phase output; must satisfy 2^pPHASE_WIDTH >= pPHASE_PERIOD.
pTIMEOUT, 1023, maximum cycles to wait for psdone after a psen pulse.

Ports:
cwusb_clk  input  1  USB register clock; also MMCM psclk.
reset_n  input  1  asynchronous, active-low reset.
I_start  input  1  one-cycle request to begin a shift sequence.
I_steps  input  pSTEP_WIDTH  signed step count, sampled on an accepted I_start.
I_abort  input  1  stop after the step currently in flight completes.
I_phase_clear  input  1  zero the tracked phase; honoured only in IDLE.
I_locked  input  1  MMCM locked.
I_psdone  input  1  MMCM phase-shift done, one-cycle pulse.
O_psen  output  1  MMCM phase-shift enable, one-cycle pulse.
O_psincdec  output  1  MMCM direction: 1 = increment, 0 = decrement.
O_busy  output  1  sequence in progress.
O_done  output  1  one-cycle completion pulse.
O_aborted  output  1  last sequence ended early because of I_abort.
O_timeout  output  1  sticky flag: psdone did not arrive within pTIMEOUT cycles.
O_remaining  output  pSTEP_WIDTH  unsigned magnitude of the steps still to issue.
O_phase  output  pPHASE_WIDTH  tracked phase, in the range 0..pPHASE_PERIOD-1.

Behaviour:
- Reset values: all outputs are 0, state is IDLE, and the timer is 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE:
  - I_start with I_steps==0: go to DONE; no psen is issued.
  - I_start with I_steps!=0: latch O_psincdec = ~I_steps[msb] and O_remaining = |I_steps|; set O_busy=1; clear O_timeout and O_aborted; go to ISSUE.
  - The most negative I_steps value gives a magnitude of 2^(pSTEP_WIDTH-1); no overflow.
  - I_phase_clear sets O_phase=0. If it coincides with I_start, both take effect.
- I_start while O_busy=1 is ignored. Direction and count do not change mid-sequence.
- Latency: I_start accepted at edge N gives O_busy=1 at N+1 and O_psen=1 during cycle N+2, provided I_locked=1.
- ISSUE:
  - If I_locked=0, hold in ISSUE with psen low, no timeout.
  - Otherwise assert O_psen for exactly one cycle, clear the timer, and go to WAIT.
  - If I_abort is pending before any psen is issued, go to DONE with O_aborted=1.
- WAIT (O_psen=0):
  - The timer increments every cycle.
  - On I_psdone: O_phase steps ±1 with wrap (inc at pPHASE_PERIOD-1 gives 0; dec at 0 gives pPHASE_PERIOD-1), and O_remaining decrements.
  - Then: go to DONE if the new remaining==0 or an abort is pending; otherwise go to ISSUE.
  - psdone and timer==pTIMEOUT in the same cycle: psdone wins.
  - Timer reaches pTIMEOUT without psdone: go to ERR.
  - I_psdone outside WAIT is ignored and leaves O_phase unchanged.
- Abort:
  - I_abort during any busy cycle sets the abort-pending flag.
  - The step in flight always completes and is counted.
  - O_remaining keeps the un-issued count, and O_aborted=1 at DONE.
- DONE: O_done=1 for one cycle, O_busy=0, clear abort-pending, go to IDLE.
- ERR:
  - O_timeout=1 (sticky until the next accepted I_start), O_busy=0, go to IDLE.
  - O_done is not pulsed, O_phase is not updated, and O_remaining holds its value.
- Minimum spacing between psen pulses is psdone latency + 2 cycles.
- At most one psen is outstanding at any time.
- reset_n low mid-sequence: everything returns to reset values immediately, including O_phase=0. Software must re-align after an MMCM reset.

Test Plan:
- I_steps=+3, I_locked=1, psdone 12 cycles after each psen -> 3 psen pulses with O_psincdec=1 and 14-cycle spacing; O_phase 0→3; O_done pulse; O_remaining=0.
- Phase at 0, I_steps=-2 -> O_psincdec=0; O_phase goes 1119 then 1118; O_done once.
- I_steps=5, I_abort asserted during the 2nd WAIT -> exactly 2 psen pulses; O_remaining=3; O_aborted=1; O_phase=+2.
- I_steps=1 with psdone never returned -> O_psen once; after 1023 cycles O_timeout=1, O_busy=0, no O_done, O_phase unchanged; the next I_start clears O_timeout.
- I_locked=0 at start, raised 50 cycles later -> no psen while unlocked, no timeout; psen the cycle after ISSUE sees lock; I_start pulsed while busy has no effect.
- I_steps=0 -> O_done at N+1 with no psen; I_phase_clear in IDLE → O_phase=0; reset_n pulsed mid-WAIT → all outputs 0.
